// File: rtl/ps2_pkg.sv
// Shared types, scan-code constants and the set-2 scan-code to ASCII map for the PS/2
// keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frame_state_e;
    typedef enum logic [1:0] {StNormal, StBreak, StExt, StExtBreak} dec_state_e;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef struct packed {
        logic       printable;
        logic [7:0] ch;
    } ascii_t;

    function automatic ascii_t scan2ascii(input logic [7:0] code, input logic shift);
        ascii_t     r;
        logic [7:0] lc;
        logic       letter;
        r      = '{printable: 1'b0, ch: 8'h00};
        lc     = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
            8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
            8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
            8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
            8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
            8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
            8'h35: lc = "y";  8'h1A: lc = "z";
            default: letter = 1'b0;
        endcase
        if (letter) begin
            r.printable = 1'b1;
            r.ch        = shift ? (lc - 8'h20) : lc;
        end else begin
            case (code)
                8'h45: r = '{printable: 1'b1, ch: "0"};
                8'h16: r = '{printable: 1'b1, ch: "1"};
                8'h1E: r = '{printable: 1'b1, ch: "2"};
                8'h26: r = '{printable: 1'b1, ch: "3"};
                8'h25: r = '{printable: 1'b1, ch: "4"};
                8'h2E: r = '{printable: 1'b1, ch: "5"};
                8'h36: r = '{printable: 1'b1, ch: "6"};
                8'h3D: r = '{printable: 1'b1, ch: "7"};
                8'h3E: r = '{printable: 1'b1, ch: "8"};
                8'h46: r = '{printable: 1'b1, ch: "9"};
                8'h29: r = '{printable: 1'b1, ch: 8'h20};
                default: r = '{printable: 1'b0, ch: 8'h00};
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Output bundle of the PS/2 keyboard receiver: last character plus one-cycle event strobes.
interface ps2_keyboard_rx_if;

    logic [7:0] data_o;
    logic       valid_o;
    logic       done_o;
    logic       reset_o;
    logic       err_o;

    modport master (output data_o, valid_o, done_o, reset_o, err_o);
    modport slave  (input  data_o, valid_o, done_o, reset_o, err_o);

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchronizers, 11-bit frame FSM and inter-edge timeout. Odd-parity checking is
// built only when PS2_PARITY_CHECK_EN is defined. Byte and error strobes are combinational.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall, dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign dat  = dat_sync_q[SYNC_STAGES-1];

    frame_state_e    state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shreg_q;
    logic [CntW-1:0] tmo_cnt_q;
    logic            tmo_hit, parity_ok, stop_ok;

    // An edge arriving on the expiry cycle wins over the timeout.
    assign tmo_hit = (state_q != StIdle) && !fall && (tmo_cnt_q == CntW'(TIMEOUT_CYC - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;
    assign parity_ok = ^{shreg_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tmo_cnt_q <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q  <= 1'b0;
`endif
        end else if (fall) begin
            tmo_cnt_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (!dat) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                    end
                end
                StData: begin
                    shreg_q   <= {dat, shreg_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_q <= StParity;
                end
                StParity: begin
`ifdef PS2_PARITY_CHECK_EN
                    parity_q <= dat;
`endif
                    state_q  <= StStop;
                end
                StStop:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end else if (tmo_hit) begin
            state_q   <= StIdle;
            tmo_cnt_q <= '0;
        end else if (state_q != StIdle) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign stop_ok  = dat & parity_ok;
    assign rx_byte  = shreg_q;
    assign rx_valid = fall && (state_q == StStop) && stop_ok;
    assign rx_err   = (fall && (state_q == StStop) && !stop_ok) || tmo_hit;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame receiver plus make/break/extended decoder that turns
// scan codes into ASCII, Enter and Escape events. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk_i,
    input  logic              ps2_dat_i,
    ps2_keyboard_rx_if.master key_if
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    ps2_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk_i(ps2_clk_i),
        .ps2_dat_i(ps2_dat_i),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    dec_state_e dec_q;
    logic       shift_q;
    logic [7:0] data_q;
    logic       valid_q, done_q, esc_q, err_q;
    ascii_t     asc;
    logic       is_shift;

    assign asc      = scan2ascii(rx_byte, shift_q);
    assign is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_q   <= StNormal;
            shift_q <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            esc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            esc_q   <= 1'b0;
            err_q   <= rx_err;
            if (rx_valid) begin
                unique case (dec_q)
                    StNormal: begin
                        if (rx_byte == SC_BREAK) begin
                            dec_q <= StBreak;
                        end else if (rx_byte == SC_EXT) begin
                            dec_q <= StExt;
                        end else if (is_shift) begin
                            shift_q <= 1'b1;
                        end else if (rx_byte == SC_ENTER) begin
                            done_q <= 1'b1;
                        end else if (rx_byte == SC_ESC) begin
                            esc_q <= 1'b1;
                        end else if (asc.printable) begin
                            data_q  <= asc.ch;
                            valid_q <= 1'b1;
                        end
                    end
                    StBreak: begin
                        if (is_shift) shift_q <= 1'b0;
                        dec_q <= StNormal;
                    end
                    // Extended makes other than keypad Enter are swallowed.
                    StExt: begin
                        if (rx_byte == SC_BREAK) begin
                            dec_q <= StExtBreak;
                        end else begin
                            dec_q <= StNormal;
                            if (rx_byte == SC_ENTER) done_q <= 1'b1;
                        end
                    end
                    StExtBreak: dec_q <= StNormal;
                    default:    dec_q <= StNormal;
                endcase
            end
        end
    end

    assign key_if.data_o  = data_q;
    assign key_if.valid_o = valid_q;
    assign key_if.done_o  = done_q;
    assign key_if.reset_o = esc_q;
    assign key_if.err_o   = err_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: vector table of key sequences, frame-level corner cases and a
// randomized scan-code stream checked against a keyboard-level reference model.
module tb_ps2_keyboard_rx;

    localparam int unsigned TMO = 200;
    localparam int          HP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;

    ps2_keyboard_rx_if key_if ();

    ps2_keyboard_rx #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk_i(ps2_clk),
        .ps2_dat_i(ps2_dat),
        .key_if   (key_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_done = 0, n_reset = 0, n_err = 0, n_multi = 0;

    always @(negedge clk) begin
        if (key_if.valid_o) n_valid++;
        if (key_if.done_o)  n_done++;
        if (key_if.reset_o) n_reset++;
        if (key_if.err_o)   n_err++;
        if (int'(key_if.valid_o) + int'(key_if.done_o) + int'(key_if.reset_o)
            + int'(key_if.err_o) > 1) n_multi++;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_range(input logic [10:0] fr, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) ps2_bit(fr[i]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_range(mk_frame(b, bad_par), 0, 10);
        ps2_dat = 1'b1;
        repeat (4 * HP) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] codes [7];
        int         n;
        int         ev, ed, er;
        logic [7:0] edata;
    } vec_t;

    function automatic vec_t mk(input int n, input int ev, input int ed, input int er,
                                input logic [7:0] edata,
                                input logic [7:0] c0, input logic [7:0] c1 = 8'h00,
                                input logic [7:0] c2 = 8'h00, input logic [7:0] c3 = 8'h00,
                                input logic [7:0] c4 = 8'h00, input logic [7:0] c5 = 8'h00,
                                input logic [7:0] c6 = 8'h00);
        vec_t v;
        v.codes = '{c0, c1, c2, c3, c4, c5, c6};
        v.n = n; v.ev = ev; v.ed = ed; v.er = er; v.edata = edata;
        return v;
    endfunction

    // Reference keyboard model: pending-break / pending-extended flags plus a shift flag.
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
        8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
        8'h3E, 8'h46};
    bit         m_shift = 0, m_brk = 0, m_ext = 0;
    logic [7:0] m_data = 8'h00;

    task automatic model(input logic [7:0] c, output int ev, output int ed, output int er);
        ev = 0; ed = 0; er = 0;
        if (m_brk) begin
            if (!m_ext && (c == 8'h12 || c == 8'h59)) m_shift = 0;
            m_brk = 0;
            m_ext = 0;
        end else if (c == 8'hF0) begin
            m_brk = 1;
        end else if (m_ext) begin
            m_ext = 0;
            if (c == 8'h5A) ed = 1;
        end else if (c == 8'hE0) begin
            m_ext = 1;
        end else if (c == 8'h12 || c == 8'h59) begin
            m_shift = 1;
        end else if (c == 8'h5A) begin
            ed = 1;
        end else if (c == 8'h76) begin
            er = 1;
        end else if (c == 8'h29) begin
            ev = 1; m_data = 8'h20;
        end else begin
            for (int i = 0; i < 26; i++)
                if (letter_codes[i] == c) begin
                    ev = 1;
                    m_data = (m_shift ? 8'h41 : 8'h61) + 8'(i);
                end
            for (int i = 0; i < 10; i++)
                if (digit_codes[i] == c) begin
                    ev = 1;
                    m_data = 8'h30 + 8'(i);
                end
        end
    endtask

    vec_t vecs [12];

    initial begin
        int v0, d0, r0, e0;
        logic [10:0] fr;

        vecs[0]  = mk(3, 1, 0, 0, 8'h61, 8'h1C, 8'hF0, 8'h1C);
        vecs[1]  = mk(7, 2, 0, 0, 8'h61, 8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C);
        vecs[2]  = mk(1, 0, 1, 0, 8'h61, 8'h5A);
        vecs[3]  = mk(2, 0, 1, 0, 8'h61, 8'hE0, 8'h5A);
        vecs[4]  = mk(1, 0, 0, 1, 8'h61, 8'h76);
        vecs[5]  = mk(1, 1, 0, 0, 8'h20, 8'h29);
        vecs[6]  = mk(4, 1, 0, 0, 8'h30, 8'h12, 8'h45, 8'hF0, 8'h12);
        vecs[7]  = mk(3, 0, 0, 0, 8'h30, 8'hE0, 8'hF0, 8'h5A);
        vecs[8]  = mk(2, 0, 0, 0, 8'h30, 8'hE0, 8'h1C);
        vecs[9]  = mk(2, 0, 0, 0, 8'h30, 8'hF0, 8'h29);
        vecs[10] = mk(1, 0, 0, 0, 8'h30, 8'h0D);
        vecs[11] = mk(4, 1, 0, 0, 8'h46, 8'h59, 8'h2B, 8'hF0, 8'h59);

        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_data",  int'(key_if.data_o), 0);
        check("reset_pulses", int'({key_if.valid_o, key_if.done_o, key_if.reset_o,
                                    key_if.err_o}), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 12; k++) begin
            v0 = n_valid; d0 = n_done; r0 = n_reset; e0 = n_err;
            for (int j = 0; j < vecs[k].n; j++) send_byte(vecs[k].codes[j], 1'b0);
            check($sformatf("vec%0d_valid", k), n_valid - v0, vecs[k].ev);
            check($sformatf("vec%0d_done", k),  n_done - d0,  vecs[k].ed);
            check($sformatf("vec%0d_reset", k), n_reset - r0, vecs[k].er);
            check($sformatf("vec%0d_err", k),   n_err - e0,   0);
            check($sformatf("vec%0d_data", k),  int'(key_if.data_o), int'(vecs[k].edata));
        end

        // Shifted letter mid-sequence.
        send_byte(8'h12, 1'b0);
        send_byte(8'h1C, 1'b0);
        check("shift_upper", int'(key_if.data_o), 8'h41);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h12, 1'b0);

        // Wrong parity on '1'.
        v0 = n_valid; e0 = n_err;
        send_byte(8'h16, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err",   n_err - e0, 1);
        check("par_valid", n_valid - v0, 0);
        check("par_data",  int'(key_if.data_o), 8'h41);
`else
        check("par_err",   n_err - e0, 0);
        check("par_valid", n_valid - v0, 1);
        check("par_data",  int'(key_if.data_o), 8'h31);
`endif

        // Long but legal gap between edges: no timeout.
        v0 = n_valid; e0 = n_err;
        fr = mk_frame(8'h1A, 1'b0);
        send_range(fr, 0, 4);
        repeat (TMO - 2 * HP - 20) @(negedge clk);
        send_range(fr, 5, 10);
        ps2_dat = 1'b1;
        repeat (4 * HP) @(negedge clk);
        check("slow_err",   n_err - e0, 0);
        check("slow_valid", n_valid - v0, 1);
        check("slow_data",  int'(key_if.data_o), 8'h7A);

        // Clock stalls after 4 data bits.
        v0 = n_valid; e0 = n_err;
        send_range(mk_frame(8'h55, 1'b0), 0, 4);
        ps2_dat = 1'b1;
        repeat (TMO + 10) @(negedge clk);
        check("tmo_err",   n_err - e0, 1);
        check("tmo_valid", n_valid - v0, 0);
        check("tmo_idle",  int'(dut.u_frame.state_q), 0);
        send_byte(8'h29, 1'b0);
        check("tmo_next_data",  int'(key_if.data_o), 8'h20);
        check("tmo_next_valid", n_valid - v0, 1);
        check("tmo_next_err",   n_err - e0, 1);

        // Reset pulse mid-frame.
        e0 = n_err;
        send_range(mk_frame(8'h45, 1'b0), 0, 3);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data",   int'(key_if.data_o), 0);
        check("midrst_pulses", int'({key_if.valid_o, key_if.done_o, key_if.reset_o,
                                     key_if.err_o}), 0);
        rst = 1'b1;
        ps2_dat = 1'b1;
        repeat (TMO + 20) @(negedge clk);
        check("midrst_no_err", n_err - e0, 0);
        v0 = n_valid;
        send_byte(8'h45, 1'b0);
        check("midrst_next_data",  int'(key_if.data_o), 8'h30);
        check("midrst_next_valid", n_valid - v0, 1);
        check("midrst_next_err",   n_err - e0, 0);

        // Random scan-code stream against the model.
        m_data = 8'h30;
        for (int k = 0; k < 60; k++) begin
            logic [7:0] c;
            int sel, ev, ed, er;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: c = letter_codes[$urandom_range(0, 25)];
                4:          c = digit_codes[$urandom_range(0, 9)];
                5:          c = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
                6:          c = 8'hF0;
                7:          c = 8'hE0;
                8: begin
                    sel = $urandom_range(0, 2);
                    c = (sel == 0) ? 8'h5A : ((sel == 1) ? 8'h76 : 8'h29);
                end
                default:    c = 8'($urandom_range(0, 255));
            endcase
            model(c, ev, ed, er);
            v0 = n_valid; d0 = n_done; r0 = n_reset; e0 = n_err;
            send_byte(c, 1'b0);
            check($sformatf("rnd%0d_valid_%02h", k, c), n_valid - v0, ev);
            check($sformatf("rnd%0d_done_%02h", k, c),  n_done - d0,  ed);
            check($sformatf("rnd%0d_reset_%02h", k, c), n_reset - r0, er);
            check($sformatf("rnd%0d_err_%02h", k, c),   n_err - e0,   0);
            check($sformatf("rnd%0d_data_%02h", k, c),  int'(key_if.data_o), int'(m_data));
        end

        check("one_hot_pulses", n_multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
